// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and the per-target state type for the read crossbar.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TGT_IDLE = 2'd0,
        TGT_ADDR = 2'd1,
        TGT_DATA = 2'd2
    } tgt_state_e;

endpackage

// File: rtl/axil_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant; the winner pointer only moves on advance.
module axil_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  last_reg;
    logic [PW-1:0]  last_next;
    logic [PW:0]    shamt;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] grant_dbl;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_reg <= PW'(N - 1);
        end else if (advance) begin
            last_reg <= last_next;
        end
    end

    // Rotate so the search starts just past the last winner, take the lowest set bit, rotate back.
    always_comb begin
        shamt     = {1'b0, last_reg} + (PW+1)'(1);
        req_rot   = N'({req, req} >> shamt);
        pick      = req_rot & (~req_rot + N'(1));
        grant_dbl = {{N{1'b0}}, pick} << shamt;
        grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];
    end

    always_comb begin
        last_next = last_reg;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                last_next = PW'(i);
            end
        end
    end

endmodule

// File: rtl/axil_xbar_rd_rr.sv
// AXI-Lite read crossbar: NUM_M masters to NUM_S slaves plus an internal decode-error target,
// one round-robin arbitrated transaction in flight per target.
module axil_xbar_rd_rr
    import axil_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_S-1:0][ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_S-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   m_axil_araddr  [NUM_M],
    input  logic [NUM_M-1:0]    m_axil_arvalid,
    output logic [NUM_M-1:0]    m_axil_arready,
    output logic [DATA_W-1:0]   m_axil_rdata   [NUM_M],
    output logic [1:0]          m_axil_rresp   [NUM_M],
    output logic [NUM_M-1:0]    m_axil_rvalid,
    input  logic [NUM_M-1:0]    m_axil_rready,
    output logic [ADDR_W-1:0]   s_axil_araddr  [NUM_S],
    output logic [NUM_S-1:0]    s_axil_arvalid,
    input  logic [NUM_S-1:0]    s_axil_arready,
    input  logic [DATA_W-1:0]   s_axil_rdata   [NUM_S],
    input  logic [1:0]          s_axil_rresp   [NUM_S],
    input  logic [NUM_S-1:0]    s_axil_rvalid,
    output logic [NUM_S-1:0]    s_axil_rready,
    output logic [NUM_S:0]      tgt_busy
);
    localparam int NUM_T = NUM_S + 1;
    localparam int TW    = $clog2(NUM_T);

    logic [TW-1:0]     m_dec      [NUM_M];
    logic [NUM_M-1:0]  m_granted;
    logic [NUM_M-1:0]  t_ar_mask  [NUM_T];
    logic [NUM_M-1:0]  t_r_mask   [NUM_T];
    logic              t_arready  [NUM_T];
    logic              t_rvalid   [NUM_T];
    logic [DATA_W-1:0] t_rdata    [NUM_T];
    logic [1:0]        t_rresp    [NUM_T];

    genvar gi;

    // Address decode; the lowest matching slave wins, no match lands on the error target.
    for (gi = 0; gi < NUM_M; gi++) begin : g_dec
        logic [TW-1:0] dec;
        always_comb begin
            dec = TW'(NUM_S);
            for (int j = NUM_S - 1; j >= 0; j--) begin
                if ((m_axil_araddr[gi] & SLV_MASK[j]) == SLV_BASE[j]) begin
                    dec = TW'(j);
                end
            end
        end
        assign m_dec[gi] = dec;
    end

    always_comb begin
        m_granted = '0;
        for (int j = 0; j < NUM_T; j++) begin
            m_granted = m_granted | t_ar_mask[j] | t_r_mask[j];
        end
    end

    for (gi = 0; gi < NUM_T; gi++) begin : g_tgt
        tgt_state_e       state_reg;
        tgt_state_e       state_next;
        logic [NUM_M-1:0] grant_reg;
        logic [NUM_M-1:0] req_vec;
        logic [NUM_M-1:0] arb_req;
        logic [NUM_M-1:0] arb_grant;
        logic [NUM_M-1:0] ar_mask;
        logic [NUM_M-1:0] r_mask;
        logic             busy;
        logic             sel_arvalid;
        logic             sel_rready;
        logic             ar_hs;
        logic             r_hs;

        always_comb begin
            req_vec = '0;
            for (int i = 0; i < NUM_M; i++) begin
                req_vec[i] = m_axil_arvalid[i] && (m_dec[i] == TW'(gi)) && !m_granted[i];
            end
        end

        // Outside IDLE the arbiter sees the held grant, so advance records the actual winner.
        assign arb_req = (state_reg == TGT_IDLE) ? req_vec : grant_reg;

        axil_rr_arbiter #(.N(NUM_M)) u_arb (
            .aclk    (aclk),
            .areset  (areset),
            .req     (arb_req),
            .advance (r_hs),
            .grant   (arb_grant)
        );

        assign sel_arvalid = |(grant_reg & m_axil_arvalid);
        assign sel_rready  = |(grant_reg & m_axil_rready);
        assign ar_hs       = (state_reg == TGT_ADDR) && sel_arvalid && t_arready[gi];
        assign r_hs        = (state_reg == TGT_DATA) && t_rvalid[gi] && sel_rready;

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                state_reg <= TGT_IDLE;
                grant_reg <= '0;
            end else begin
                state_reg <= state_next;
                if (state_reg == TGT_IDLE) begin
                    grant_reg <= arb_grant;
                end
            end
        end

        always_comb begin
            state_next = state_reg;
            case (state_reg)
                TGT_IDLE: if (|req_vec) state_next = TGT_ADDR;
                TGT_ADDR: if (ar_hs)    state_next = TGT_DATA;
                TGT_DATA: if (r_hs)     state_next = TGT_IDLE;
                default:                state_next = TGT_IDLE;
            endcase
        end

        always_comb begin
            ar_mask = '0;
            r_mask  = '0;
            busy    = 1'b0;
            case (state_reg)
                TGT_ADDR: begin
                    ar_mask = grant_reg;
                    busy    = 1'b1;
                end
                TGT_DATA: begin
                    r_mask = grant_reg;
                    busy   = 1'b1;
                end
                default: ;
            endcase
        end

        assign t_ar_mask[gi] = ar_mask;
        assign t_r_mask[gi]  = r_mask;
        assign tgt_busy[gi]  = busy;

        if (gi < NUM_S) begin : g_slv
            logic [ADDR_W-1:0] addr_mux;
            always_comb begin
                addr_mux = '0;
                for (int i = 0; i < NUM_M; i++) begin
                    if (ar_mask[i]) begin
                        addr_mux = addr_mux | m_axil_araddr[i];
                    end
                end
            end
            assign s_axil_araddr[gi]  = addr_mux;
            assign s_axil_arvalid[gi] = |(ar_mask & m_axil_arvalid);
            assign s_axil_rready[gi]  = |(r_mask & m_axil_rready);
            assign t_arready[gi]      = s_axil_arready[gi];
            assign t_rvalid[gi]       = s_axil_rvalid[gi];
            assign t_rdata[gi]        = s_axil_rdata[gi];
            assign t_rresp[gi]        = s_axil_rresp[gi];
        end else begin : g_decerr
            assign t_arready[gi] = 1'b1;
            assign t_rvalid[gi]  = 1'b1;
            assign t_rdata[gi]   = '0;
            assign t_rresp[gi]   = RESP_DECERR;
        end
    end

    // A master holds at most one grant, so OR-combining target contributions is a clean mux.
    always_comb begin
        m_axil_arready = '0;
        m_axil_rvalid  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            m_axil_rdata[i] = '0;
            m_axil_rresp[i] = '0;
        end
        for (int j = 0; j < NUM_T; j++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (t_ar_mask[j][i] && t_arready[j]) begin
                    m_axil_arready[i] = 1'b1;
                end
                if (t_r_mask[j][i]) begin
                    m_axil_rvalid[i] = m_axil_rvalid[i] | t_rvalid[j];
                    m_axil_rdata[i]  = m_axil_rdata[i] | t_rdata[j];
                    m_axil_rresp[i]  = m_axil_rresp[i] | t_rresp[j];
                end
            end
        end
    end

endmodule
